// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and constants for the LEGv8 hazard/forwarding controller.
// The stage numbering used by forwarding selects lives here.
package pipeline_hazard_unit_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_ZERO_REG   = 31;

    // Forwarding select values: 0 reads the register file, k forwards from stage k.
    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        STAGE_EX  = 2'd1,
        STAGE_MEM = 2'd2,
        STAGE_WB  = 2'd3
    } fwd_src_e;

    // Per-stage scoreboard flags; the destination address is kept alongside.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic is_load;
    } sb_flags_t;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// Decode-side hazard bus: decode/branch info toward the unit and
// stall/flush/forwarding controls back to the pipeline.
interface pipeline_hazard_unit_if #(
    parameter int REG_ADDR_W     = 5,
    parameter int NUM_READ_PORTS = 2,
    parameter int BRANCH_STAGE   = 2,
    parameter int SEL_W          = 2,
    parameter int CNT_W          = 32
);
    logic                                 id_valid;
    logic [NUM_READ_PORTS-1:0]            id_rs_valid;
    logic [NUM_READ_PORTS*REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0]                id_rd_addr;
    logic                                 id_reg_write;
    logic                                 id_mem_read;
    logic                                 pc_src;

    logic                                 stall_if_id;
    logic                                 bubble_id_ex;
    logic [BRANCH_STAGE-1:0]              flush_mask;
    logic [NUM_READ_PORTS*SEL_W-1:0]      fwd_sel;
    logic [CNT_W-1:0]                     stall_count;
    logic [CNT_W-1:0]                     flush_count;

    modport master (
        output id_valid, id_rs_valid, id_rs_addr, id_rd_addr,
               id_reg_write, id_mem_read, pc_src,
        input  stall_if_id, bubble_id_ex, flush_mask, fwd_sel,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs_valid, id_rs_addr, id_rd_addr,
               id_reg_write, id_mem_read, pc_src,
        output stall_if_id, bubble_id_ex, flush_mask, fwd_sel,
               stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// Per-read-port priority comparator over the scoreboard: youngest matching
// producer wins, plus a flag for a load sitting in EX (load-use hazard).
module pipeline_hazard_unit_fwd_select
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = 2,
    parameter int ZERO_REG   = DEF_ZERO_REG
) (
    input  logic                        rs_valid,
    input  logic [REG_ADDR_W-1:0]       rs_addr,
    input  logic [DEPTH-1:0]            ent_valid,
    input  logic [DEPTH-1:0]            ent_reg_write,
    input  logic [DEPTH*REG_ADDR_W-1:0] ent_rd,
    input  logic                        ex_is_load,
    output logic [SEL_W-1:0]            sel,
    output logic                        load_hit
);
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0] match;
    logic             rs_live;

    // XZR reads always come from the register file, so they never match.
    assign rs_live = rs_valid && (rs_addr != ZERO_ADDR);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match[gi] = rs_live && ent_valid[gi] && ent_reg_write[gi]
                        && (ent_rd[gi*REG_ADDR_W +: REG_ADDR_W] == rs_addr);
    end

    // Scan oldest to youngest so the youngest producer overwrites.
    always_comb begin
        sel = SEL_W'(FWD_RF);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel = SEL_W'(i + 1);
            end
        end
    end

    assign load_hit = match[0] && ex_is_load;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard, forwarding and flush controller: shift-register scoreboard of
// in-flight destinations driving forwarding selects, load-use stall and flush.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
    parameter int NUM_READ_PORTS = 2,
    parameter int DEPTH          = 3,
    parameter int BRANCH_STAGE   = 2,
    parameter int ZERO_REG       = DEF_ZERO_REG,
    parameter int SEL_W          = 2,
    parameter int CNT_W          = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_unit_if.slave  hz
);
    sb_flags_t             flags_q [1:DEPTH];
    sb_flags_t             flags_d [1:DEPTH];
    logic [REG_ADDR_W-1:0] rd_q    [1:DEPTH];
    logic [REG_ADDR_W-1:0] rd_d    [1:DEPTH];
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic [DEPTH-1:0]                     ent_valid;
    logic [DEPTH-1:0]                     ent_wr;
    logic [DEPTH*REG_ADDR_W-1:0]          ent_rd;
    logic [NUM_READ_PORTS-1:0]            load_hit;
    logic [NUM_READ_PORTS*SEL_W-1:0]      sel_raw;
    logic                                 flush;
    logic                                 load_use;
    logic                                 stall;

    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_flatten
        assign ent_valid[gi-1]                          = flags_q[gi].valid;
        assign ent_wr[gi-1]                             = flags_q[gi].reg_write;
        assign ent_rd[(gi-1)*REG_ADDR_W +: REG_ADDR_W]  = rd_q[gi];
    end

    for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_port
        pipeline_hazard_unit_fwd_select #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .SEL_W      (SEL_W),
            .ZERO_REG   (ZERO_REG)
        ) u_fwd_select (
            .rs_valid      (hz.id_rs_valid[gi]),
            .rs_addr       (hz.id_rs_addr[gi*REG_ADDR_W +: REG_ADDR_W]),
            .ent_valid     (ent_valid),
            .ent_reg_write (ent_wr),
            .ent_rd        (ent_rd),
            .ex_is_load    (flags_q[int'(STAGE_EX)].is_load),
            .sel           (sel_raw[gi*SEL_W +: SEL_W]),
            .load_hit      (load_hit[gi])
        );
    end

    // A taken branch kills the stalled instruction anyway, so flush wins.
    assign flush    = hz.pc_src;
    assign load_use = hz.id_valid && (|load_hit);
    assign stall    = load_use && !flush;

    always_comb begin
        flags_d[1] = (flush || stall) ? '0 : '{valid:     hz.id_valid,
                                               reg_write: hz.id_reg_write,
                                               is_load:   hz.id_mem_read};
        rd_d[1]    = hz.id_rd_addr;
        for (int k = 2; k <= DEPTH; k++) begin
            flags_d[k] = (flush && (k <= BRANCH_STAGE)) ? '0 : flags_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
    end

    assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                flags_q[k] <= '0;
                rd_q[k]    <= '0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            flags_q     <= flags_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs are forced low while reset is held, even if pc_src is high.
    assign hz.stall_if_id  = stall && !reset;
    assign hz.bubble_id_ex = stall && !reset;
    assign hz.flush_mask   = {BRANCH_STAGE{flush && !reset}};
    assign hz.fwd_sel      = (hz.id_valid && !reset) ? sel_raw : '0;
    assign hz.stall_count  = stall_cnt_q;
    assign hz.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: an instruction-level model
// checked every negedge, plus hand-computed expectations at key points.
module tb_pipeline_hazard_unit;
    localparam int W  = 5;
    localparam int NP = 2;
    localparam int D  = 3;
    localparam int BS = 2;
    localparam int SW = 2;
    localparam int CW = 4;
    localparam int ZR = 31;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_unit_if #(
        .REG_ADDR_W(W), .NUM_READ_PORTS(NP), .BRANCH_STAGE(BS), .SEL_W(SW), .CNT_W(CW)
    ) hz ();

    pipeline_hazard_unit #(
        .REG_ADDR_W(W), .NUM_READ_PORTS(NP), .DEPTH(D), .BRANCH_STAGE(BS),
        .ZERO_REG(ZR), .SEL_W(SW), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } ent_t;

    ent_t m [1:D];
    int   m_stall = 0;
    int   m_flush = 0;

    function automatic ent_t empty_e();
        ent_t e;
        e.v = 1'b0; e.rd = 0; e.wr = 1'b0; e.ld = 1'b0;
        return e;
    endfunction

    // Youngest in-flight writer of the register read on port p, 0 if none.
    function automatic int exp_sel(input int p);
        int rs;
        if (reset || !hz.id_valid || !hz.id_rs_valid[p]) return 0;
        rs = int'(hz.id_rs_addr[p*W +: W]);
        if (rs == ZR) return 0;
        for (int k = 1; k <= D; k++) begin
            if (m[k].v && m[k].wr && m[k].rd == rs) return k;
        end
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit hit;
        hit = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (exp_sel(p) == 1 && m[1].ld) hit = 1'b1;
        end
        return hit && !hz.pc_src && !reset;
    endfunction

    always @(negedge clk) begin
        chk("stall_if_id", int'(hz.stall_if_id), int'(exp_stall()));
        chk("bubble_id_ex", int'(hz.bubble_id_ex), int'(exp_stall()));
        chk("flush_mask", int'(hz.flush_mask), (hz.pc_src && !reset) ? 3 : 0);
        for (int p = 0; p < NP; p++) begin
            chk("fwd_sel", int'(hz.fwd_sel[p*SW +: SW]), exp_sel(p));
        end
        chk("stall_count", int'(hz.stall_count), m_stall);
        chk("flush_count", int'(hz.flush_count), m_flush);
    end

    always @(posedge clk or posedge reset) begin : model_update
        bit   st;
        bit   fl;
        ent_t dec;
        if (reset) begin
            for (int k = 1; k <= D; k++) m[k] <= empty_e();
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            st     = exp_stall();
            fl     = hz.pc_src;
            dec.v  = hz.id_valid;
            dec.rd = int'(hz.id_rd_addr);
            dec.wr = hz.id_reg_write;
            dec.ld = hz.id_mem_read;
            m[3] <= m[2];
            m[2] <= fl ? empty_e() : m[1];
            m[1] <= (fl || st) ? empty_e() : dec;
            if (st && m_stall < CNT_MAX) m_stall <= m_stall + 1;
            if (fl && m_flush < CNT_MAX) m_flush <= m_flush + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_instr(input string nm, input bit v, input int rd, input bit wr,
                             input bit ld, input bit r0v, input int r0,
                             input bit r1v, input int r1);
        hz.id_valid     = v;
        hz.id_rd_addr   = W'(rd);
        hz.id_reg_write = wr;
        hz.id_mem_read  = ld;
        hz.id_rs_valid  = {r1v, r0v};
        hz.id_rs_addr   = {W'(r1), W'(r0)};
        $display("t=%0t issue %s valid=%0d rd=X%0d rs0=X%0d rs1=X%0d", $time, nm, v, rd, r0, r1);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int fsel(input int p);
        return int'(hz.fwd_sel[p*SW +: SW]);
    endfunction

    initial begin
        hz.pc_src = 1'b0;
        set_instr("NOP", 0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("rst_stall", int'(hz.stall_if_id), 0);
        chk("rst_stall_count", int'(hz.stall_count), 0);
        #1 reset = 1'b0;

        // Load-use stall, then reset pulse at 12 ns in the middle of it.
        set_instr("LDUR X4,[X9]", 1, 4, 1, 1, 1, 9, 0, 0);
        cyc();                                              // t=6
        set_instr("ADD X5,X4,X4", 1, 5, 1, 0, 1, 4, 1, 4);
        #1;
        chk("lu_pre_reset_stall", int'(hz.stall_if_id), 1);
        chk("lu_pre_reset_bubble", int'(hz.bubble_id_ex), 1);
        #5;                                                 // t=12
        reset = 1'b1;
        hz.pc_src = 1'b1;
        #1;
        chk("midrst_stall", int'(hz.stall_if_id), 0);
        chk("midrst_bubble", int'(hz.bubble_id_ex), 0);
        chk("midrst_flush_mask", int'(hz.flush_mask), 0);
        chk("midrst_fwd0", fsel(0), 0);
        chk("midrst_stall_count", int'(hz.stall_count), 0);
        reset = 1'b0;
        hz.pc_src = 1'b0;
        #1;
        chk("release_stall", int'(hz.stall_if_id), 0);
        chk("release_fwd0", fsel(0), 0);
        chk("release_fwd1", fsel(1), 0);
        chk("release_flush_count", int'(hz.flush_count), 0);
        cyc();

        // Back-to-back ALU forwarding from EX, then from MEM.
        set_instr("ADD X1,X2,X3", 1, 1, 1, 0, 1, 2, 1, 3);
        cyc();
        set_instr("SUB X2,X1,X3", 1, 2, 1, 0, 1, 1, 1, 3);
        #1;
        chk("alu_fwd0_ex", fsel(0), 1);
        chk("alu_fwd1_rf", fsel(1), 0);
        chk("alu_no_stall", int'(hz.stall_if_id), 0);
        cyc();
        set_instr("ADD X6,X1,X7", 1, 6, 1, 0, 1, 1, 1, 7);
        #1;
        chk("alu_fwd0_mem", fsel(0), 2);

        // Load-use: one stall cycle, then both ports forward from MEM.
        cyc();
        set_instr("LDUR X4,[X9]", 1, 4, 1, 1, 1, 9, 0, 0);
        cyc();
        set_instr("ADD X5,X4,X4", 1, 5, 1, 0, 1, 4, 1, 4);
        #1;
        chk("lu_stall", int'(hz.stall_if_id), 1);
        chk("lu_bubble", int'(hz.bubble_id_ex), 1);
        chk("lu_stall_count_before", int'(hz.stall_count), 0);
        cyc();
        chk("lu_stall_count_after", int'(hz.stall_count), 1);
        chk("lu_released", int'(hz.stall_if_id), 0);
        chk("lu_fwd0_mem", fsel(0), 2);
        chk("lu_fwd1_mem", fsel(1), 2);

        // Invalid decode slot: no stall and selects forced to 0.
        cyc();
        set_instr("LDUR X8,[X10]", 1, 8, 1, 1, 1, 10, 0, 0);
        cyc();
        set_instr("bubble reading X8", 0, 0, 0, 0, 1, 8, 1, 8);
        #1;
        chk("inv_no_stall", int'(hz.stall_if_id), 0);
        chk("inv_fwd0", fsel(0), 0);
        chk("inv_fwd1", fsel(1), 0);
        cyc();

        // Two producers of X1: the younger one (EX) wins.
        set_instr("ADD X1,X2,X3", 1, 1, 1, 0, 1, 2, 1, 3);
        cyc();
        set_instr("ADD X7,X2,X3", 1, 7, 1, 0, 1, 2, 1, 3);
        cyc();
        set_instr("ADD X1,X2,X3", 1, 1, 1, 0, 1, 2, 1, 3);
        cyc();
        set_instr("ADD X9,X1,X7", 1, 9, 1, 0, 1, 1, 1, 7);
        #1;
        chk("dual_fwd0_young", fsel(0), 1);
        chk("dual_fwd1_mem", fsel(1), 2);

        // Writes to XZR are never forwarded and never stall.
        cyc();
        set_instr("LDUR X31,[X2]", 1, 31, 1, 1, 1, 2, 0, 0);
        cyc();
        set_instr("ADD X10,X31,X31", 1, 10, 1, 0, 1, 31, 1, 31);
        #1;
        chk("xzr_fwd0", fsel(0), 0);
        chk("xzr_fwd1", fsel(1), 0);
        chk("xzr_no_stall", int'(hz.stall_if_id), 0);

        // Branch resolves while a load-use stall is pending: flush wins.
        cyc();
        set_instr("BL X30", 1, 30, 1, 0, 0, 0, 0, 0);
        cyc();
        set_instr("LDUR X4,[X9]", 1, 4, 1, 1, 1, 9, 0, 0);
        cyc();
        set_instr("ADD X5,X4,X4", 1, 5, 1, 0, 1, 4, 1, 4);
        hz.pc_src = 1'b1;
        #1;
        chk("flush_mask", int'(hz.flush_mask), 3);
        chk("flush_no_stall", int'(hz.stall_if_id), 0);
        chk("flush_no_bubble", int'(hz.bubble_id_ex), 0);
        cyc();
        hz.pc_src = 1'b0;
        set_instr("ADD X11,X4,X30", 1, 11, 1, 0, 1, 4, 1, 30);
        #1;
        chk("flush_count_one", int'(hz.flush_count), 1);
        chk("flush_stall_count_kept", int'(hz.stall_count), 1);
        chk("flush_killed_load", fsel(0), 0);
        chk("flush_branch_in_wb", fsel(1), 3);

        // Counter saturation: a self-dependent load stalls every other cycle.
        cyc();
        set_instr("LDUR X4,[X4] loop", 1, 4, 1, 1, 1, 4, 0, 0);
        for (int i = 0; i < 40; i++) cyc();
        chk("stall_count_sat", int'(hz.stall_count), CNT_MAX);
        hz.pc_src = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        chk("flush_count_sat", int'(hz.flush_count), CNT_MAX);
        chk("stall_count_hold", int'(hz.stall_count), CNT_MAX);
        hz.pc_src = 1'b0;
        set_instr("NOP", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
